// File: rtl/vco_pkg.sv
// Shared constants for the VCO bank: waveform mode encoding
// and default parameter values.
package vco_pkg;

  localparam logic [1:0] MODE_SAW    = 2'd0;
  localparam logic [1:0] MODE_SQUARE = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;

  localparam int DEF_N_CH    = 4;
  localparam int DEF_V_W     = 8;
  localparam int DEF_PHASE_W = 16;
  localparam int DEF_OUT_W   = 8;
  localparam int DEF_F0      = 16;
  localparam int DEF_K_SHIFT = 2;
  localparam int CNT_W       = 16;

endpackage

// File: rtl/vco_channel.sv
// One oscillator: phase accumulator, wrap flag, waveform mapper.
// Optional wrap counter under VCO_BANK_WRAP_CNT_EN.
module vco_channel
  import vco_pkg::*;
#(
  parameter int V_W     = DEF_V_W,
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int F0      = DEF_F0,
  parameter int K_SHIFT = DEF_K_SHIFT
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_sync,
  input  logic [V_W-1:0]     i_v,
  input  logic [1:0]         i_mode,
`ifdef VCO_BANK_WRAP_CNT_EN
  output logic [CNT_W-1:0]   o_wrap_cnt,
`endif
  output logic [OUT_W-1:0]   o_v,
  output logic               o_wrap
);

  localparam logic [PHASE_W-1:0] L_F0 = PHASE_W'(F0);

  logic [PHASE_W-1:0] r_phase;
  logic               r_wrap;
  logic [PHASE_W-1:0] w_vext;
  logic [PHASE_W-1:0] w_inc;
  logic [PHASE_W:0]   w_sum;
  logic               w_msb;
  logic [OUT_W-1:0]   w_saw;
  logic [OUT_W-1:0]   w_tri;

  assign w_vext = PHASE_W'(i_v);
  assign w_inc  = L_F0 + (w_vext << K_SHIFT);
  assign w_sum  = {1'b0, r_phase} + {1'b0, w_inc};

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_phase <= '0;
      r_wrap  <= 1'b0;
    end else if (i_sync) begin
      r_phase <= '0;
      r_wrap  <= 1'b0;
    end else if (i_en) begin
      r_phase <= w_sum[PHASE_W-1:0];
      r_wrap  <= w_sum[PHASE_W];
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign w_msb = r_phase[PHASE_W-1];
  assign w_saw = r_phase[PHASE_W-1 -: OUT_W];
  assign w_tri = r_phase[PHASE_W-2 -: OUT_W];

  // Mode 3 is reserved and falls back to saw.
  always_comb begin
    o_v = w_saw;
    case (i_mode)
      MODE_SQUARE: o_v = {OUT_W{w_msb}};
      MODE_TRI:    o_v = w_msb ? ~w_tri : w_tri;
      default:     o_v = w_saw;
    endcase
  end

  assign o_wrap = r_wrap;

`ifdef VCO_BANK_WRAP_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_rst || i_sync) begin
      r_cnt <= '0;
    end else if (r_wrap && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_wrap_cnt = r_cnt;
`endif

endmodule

// File: rtl/vco_bank_model.sv
// Bank of N_CH independent phase-accumulator VCOs.
// Define VCO_BANK_WRAP_CNT_EN to add per-channel wrap counters.
module vco_bank_model
  import vco_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int V_W     = DEF_V_W,
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int F0      = DEF_F0,
  parameter int K_SHIFT = DEF_K_SHIFT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH*V_W-1:0]   v_in,
  input  logic [1:0]            mode,
  input  logic                  sync,
`ifdef VCO_BANK_WRAP_CNT_EN
  output logic [N_CH*CNT_W-1:0] wrap_cnt,
`endif
  output logic [N_CH*OUT_W-1:0] v_out,
  output logic [N_CH-1:0]       wrap
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    vco_channel #(
      .V_W     (V_W),
      .PHASE_W (PHASE_W),
      .OUT_W   (OUT_W),
      .F0      (F0),
      .K_SHIFT (K_SHIFT)
    ) u_ch (
      .clk        (clk),
      .i_rst      (rst),
      .i_en       (en[c]),
      .i_sync     (sync),
      .i_v        (v_in[c*V_W +: V_W]),
      .i_mode     (mode),
`ifdef VCO_BANK_WRAP_CNT_EN
      .o_wrap_cnt (wrap_cnt[c*CNT_W +: CNT_W]),
`endif
      .o_v        (v_out[c*OUT_W +: OUT_W]),
      .o_wrap     (wrap[c])
    );
  end

endmodule

// File: tb/tb_vco_bank_model.sv
// Directed self-checking bench for vco_bank_model (default params).
// Wrap counter checks run when VCO_BANK_WRAP_CNT_EN is defined.
module tb_vco_bank_model;

  logic        clk;
  logic        rst;
  logic [3:0]  en;
  logic [31:0] v_in;
  logic [1:0]  mode;
  logic        sync;
  logic [31:0] v_out;
  logic [3:0]  wrap;
`ifdef VCO_BANK_WRAP_CNT_EN
  logic [63:0] wrap_cnt;
`endif

  int total = 0;
  int bad   = 0;

  vco_bank_model dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .v_in     (v_in),
    .mode     (mode),
    .sync     (sync),
`ifdef VCO_BANK_WRAP_CNT_EN
    .wrap_cnt (wrap_cnt),
`endif
    .v_out    (v_out),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sync();
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 4'h0; v_in = '0; mode = 2'd0; sync = 1'b0;
    tick();
    tick();
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      #1;
      total++;
      if (v_out !== 32'h0 || wrap !== 4'h0) begin
        bad++;
        $display("FAIL reset_out mode=%0d v_out=%h wrap=%h want 0/0",
                 m, v_out, wrap);
      end
    end
    mode = 2'd0; en = 4'hF; v_in = '0;
    rst = 1'b0;
    #1;
    total++;
    if (v_out !== 32'h0 || wrap !== 4'h0) begin
      bad++;
      $display("FAIL reset_release v_out=%h wrap=%h want 0/0", v_out, wrap);
    end
    for (int i = 0; i < 16; i++) tick();
    total++;
    if (v_out !== 32'h01010101 || wrap !== 4'h0) begin
      bad++;
      $display("FAIL free_run16 v_out=%h wrap=%h want 01010101/0",
               v_out, wrap);
    end
  endtask

  task automatic test_wrap();
    logic early;
    do_sync();
    en = 4'h1; v_in = 32'h000000FF; mode = 2'd0;
    early = 1'b0;
    for (int i = 1; i <= 63; i++) begin
      tick();
      if (wrap !== 4'h0) early = 1'b1;
    end
    total++;
    if (early || v_out[7:0] !== 8'd254) begin
      bad++;
      $display("FAIL wrap_pre early=%0b saw=%0d want 0/254",
               early, v_out[7:0]);
    end
    tick();
    total++;
    if (wrap !== 4'h1 || v_out[7:0] !== 8'd3) begin
      bad++;
      $display("FAIL wrap_edge64 wrap=%h saw=%0d want 1/3", wrap, v_out[7:0]);
    end
    mode = 2'd2;
    #1;
    total++;
    if (v_out[7:0] !== 8'd6) begin
      bad++;
      $display("FAIL wrap_phase768_tri got=%0d want 6", v_out[7:0]);
    end
    mode = 2'd0;
    tick();
    total++;
    if (wrap !== 4'h0 || v_out[7:0] !== 8'd7) begin
      bad++;
      $display("FAIL wrap_width wrap=%h saw=%0d want 0/7", wrap, v_out[7:0]);
    end
  endtask

  task automatic test_sync_carry();
    do_sync();
    en = 4'hF; v_in = 32'h000000FF; mode = 2'd0;
    for (int i = 0; i < 63; i++) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    total++;
    if (v_out !== 32'h0 || wrap !== 4'h0) begin
      bad++;
      $display("FAIL sync_carry v_out=%h wrap=%h want 0/0", v_out, wrap);
    end
    tick();
    total++;
    if (wrap !== 4'h0 || v_out !== 32'h00000004) begin
      bad++;
      $display("FAIL sync_resume v_out=%h wrap=%h want 00000004/0",
               v_out, wrap);
    end
  endtask

  task automatic test_hold();
    logic moved;
    do_sync();
    en = 4'hF; v_in = 32'h0000FFFF; mode = 2'd0;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (v_out[15:0] !== 16'h1414) begin
      bad++;
      $display("FAIL hold_pre got=%h want 1414", v_out[15:0]);
    end
    en = 4'b1101;
    moved = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (v_out[15:8] !== 8'd20 || wrap[1] !== 1'b0) moved = 1'b1;
    end
    total++;
    if (moved) begin
      bad++;
      $display("FAIL hold_ch1 v1=%0d wrap1=%0b want 20/0",
               v_out[15:8], wrap[1]);
    end
    total++;
    if (v_out[7:0] !== 8'd60) begin
      bad++;
      $display("FAIL hold_ch0_adv got=%0d want 60", v_out[7:0]);
    end
  endtask

  task automatic test_modes();
    do_sync();
    en = 4'h1; v_in = 32'h000000FC; mode = 2'd2;
    for (int i = 0; i < 16; i++) tick();
    total++;
    if (v_out[7:0] !== 8'd128) begin
      bad++;
      $display("FAIL tri_4000 got=%0d want 128", v_out[7:0]);
    end
    mode = 2'd0;
    #1;
    total++;
    if (v_out[7:0] !== 8'd64) begin
      bad++;
      $display("FAIL saw_4000 got=%0d want 64", v_out[7:0]);
    end
    for (int i = 0; i < 16; i++) tick();
    en = 4'h0;
    mode = 2'd2;
    #1;
    total++;
    if (v_out[7:0] !== 8'd255) begin
      bad++;
      $display("FAIL tri_8000 got=%0d want 255", v_out[7:0]);
    end
    mode = 2'd1;
    #1;
    total++;
    if (v_out[7:0] !== 8'd255) begin
      bad++;
      $display("FAIL sq_8000 got=%0d want 255", v_out[7:0]);
    end
    mode = 2'd3;
    #1;
    total++;
    if (v_out[7:0] !== 8'd128) begin
      bad++;
      $display("FAIL mode3_8000 got=%0d want 128", v_out[7:0]);
    end
    do_sync();
    en = 4'h1; v_in = '0; mode = 2'd1;
    for (int i = 0; i < 2047; i++) tick();
    total++;
    if (v_out[7:0] !== 8'd0) begin
      bad++;
      $display("FAIL sq_7ff0 got=%0d want 0", v_out[7:0]);
    end
    tick();
    total++;
    if (v_out[7:0] !== 8'd255) begin
      bad++;
      $display("FAIL sq_8000b got=%0d want 255", v_out[7:0]);
    end
  endtask

  task automatic test_rst_midrun();
    do_sync();
    en = 4'hF; v_in = 32'hFFFFFFFF; mode = 2'd2;
    for (int i = 0; i < 63; i++) tick();
    rst = 1'b1; sync = 1'b1;
    tick();
    total++;
    if (v_out !== 32'h0 || wrap !== 4'h0) begin
      bad++;
      $display("FAIL rst_midrun v_out=%h wrap=%h want 0/0", v_out, wrap);
    end
    rst = 1'b0; sync = 1'b0; en = 4'h0;
    tick();
  endtask

`ifdef VCO_BANK_WRAP_CNT_EN
  task automatic test_wrap_cnt();
    int seen;
    do_sync();
    total++;
    if (wrap_cnt !== 64'h0) begin
      bad++;
      $display("FAIL cnt_clear got=%h want 0", wrap_cnt);
    end
    en = 4'h1; v_in = 32'h000000FF; mode = 2'd0;
    seen = 0;
    for (int i = 0; i < 400 && seen < 3; i++) begin
      tick();
      if (wrap[0]) seen++;
    end
    en = 4'h0;
    tick();
    total++;
    if (seen != 3 || wrap_cnt !== 64'h3) begin
      bad++;
      $display("FAIL cnt_three seen=%0d cnt=%h want 3/3", seen, wrap_cnt);
    end
    do_sync();
    total++;
    if (wrap_cnt !== 64'h0) begin
      bad++;
      $display("FAIL cnt_sync got=%h want 0", wrap_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_sync_carry();
    test_hold();
    test_modes();
    test_rst_midrun();
`ifdef VCO_BANK_WRAP_CNT_EN
    test_wrap_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vco_bank_model.md
VCO_BANK_MODEL -- requirements
Module: vco_bank_model

Interface
- REQ-001: Parameter N_CH, default 4, number of independent oscillator channels.
- REQ-002: Parameter V_W, default 8, control-voltage code width per channel.
- REQ-003: Parameter PHASE_W, default 16, phase accumulator width; PHASE_W SHALL be at least OUT_W+1.
- REQ-004: Parameter OUT_W, default 8, output sample width per channel.
- REQ-005: Parameter F0, default 16, free-running increment added at v_in = 0.
- REQ-006: Parameter K_SHIFT, default 2, gain as a left shift applied to v_in.
- REQ-007: clk  in  1  sole clock; all state updates on rising edge.
- REQ-008: rst  in  1  synchronous, active-high reset.
- REQ-009: en  in  N_CH  per-channel run enable.
- REQ-010: v_in  in  N_CH*V_W  packed control codes, unsigned; channel c in bits [c*V_W +: V_W].
- REQ-011: mode  in  2  waveform select, common to all channels.
- REQ-012: sync  in  1  phase-align pulse for all channels.
- REQ-013: v_out  out  N_CH*OUT_W  packed waveform samples, channel c in bits [c*OUT_W +: OUT_W].
- REQ-014: wrap  out  N_CH  registered one-cycle pulse per channel on accumulator overflow.

Function
- REQ-015: inc_c SHALL be F0 + (v_in_c << K_SHIFT), evaluated and truncated to PHASE_W bits.
- REQ-016: On each edge with rst=0, sync=0, en_c=1: phase_c <= (phase_c + inc_c) mod 2^PHASE_W; wrap_c <= carry-out of that addition.
- REQ-017: With en_c=0 (rst=0, sync=0): phase_c holds; wrap_c <= 0.
- REQ-018: sync=1 SHALL set every phase_c to 0 and every wrap_c to 0 on that edge, regardless of en and of any carry; priority rst > sync > en.
- REQ-019: v_out_c SHALL be a combinational function of phase_c and mode (zero latency from phase register; one edge from v_in/en).
- REQ-020: mode 0 (saw): v_out_c = phase_c[PHASE_W-1 -: OUT_W].
- REQ-021: mode 1 (square): v_out_c = 0 when phase_c MSB is 0, else all ones.
- REQ-022: mode 2 (triangle): v_out_c = phase_c[PHASE_W-2 -: OUT_W] when MSB is 0, else its bitwise inverse.
- REQ-023: mode 3 reserved; SHALL behave as mode 0.
- REQ-024: A mode change SHALL take effect on v_out immediately, without disturbing phase.
- REQ-025: v_in and en changes SHALL take effect at the next edge only; no glitch or partial update across channels.

Reset
- REQ-026: rst=1 SHALL clear every phase_c, wrap_c and (if compiled) wrap_cnt_c to 0 on the edge.
- REQ-027: During and after reset, v_out SHALL be 0 in all modes (f(0) = 0).
- REQ-028: Reset asserted mid-run SHALL override sync, en and a pending carry on that edge.

Configuration
- REQ-029: Macro VCO_BANK_WRAP_CNT_EN defined: add output wrap_cnt (N_CH*16), per-channel counter incremented on each wrap_c pulse, saturating at 16'hFFFF, cleared by rst and sync.
- REQ-030: Macro undefined: wrap_cnt port and counters SHALL be absent; all other behaviour identical.

Structure
- REQ-031: Package vco_pkg SHALL hold the mode encoding (MODE_SAW=0, MODE_SQUARE=1, MODE_TRI=2) and the default parameter constants.
- REQ-032: Sub-module vco_channel SHALL implement one accumulator, wrap flag, waveform mapper and optional counter; the top SHALL generate N_CH instances.

Verification (defaults N_CH=4, V_W=8, PHASE_W=16, OUT_W=8, F0=16, K_SHIFT=2)
- REQ-033: rst high 2 edges, then en=4'hF, v_in=0, mode=0 -> v_out all 0, wrap 0 at release; after 16 edges each v_out_c = 1.
- REQ-034: ch0 v_in=255 (inc 1036), en=1 -> first wrap_0 pulse on 64th edge, one cycle wide, phase_0 = 768 afterwards.
- REQ-035: sync asserted on the edge a carry would occur -> all phases 0, wrap 0, no pulse; counting resumes next edge.
- REQ-036: ch1 en=0 for 10 edges while ch0 runs -> v_out_1 constant, wrap_1 0; ch0 advances 10 increments.
- REQ-037: mode=2 with phase 0x4000 -> v_out 128; phase 0x8000 -> v_out 255; mode=1 at 0x8000 -> 255, at 0x7FFF -> 0.
- REQ-038: With VCO_BANK_WRAP_CNT_EN, three wraps on ch0 -> wrap_cnt_0 = 3; sync -> 0.
